// File: rtl/sat_arb.sv
// Two-requester round-robin saturating clamp with a one-deep result register
// and a sticky count of operations that had to be clamped.
module sat_arb #(
    parameter int CNT_W = 16
) (
    input  logic             sys_clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [31:0]      req0_d,
    input  logic [1:0]       req0_mode,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [31:0]      req1_d,
    input  logic [1:0]       req1_mode,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [23:0]      res_q,
    output logic             res_id,
    output logic             res_clamped,
    output logic [CNT_W-1:0] sat_cnt,
    input  logic             cnt_clr
);

    // Handshake: a transfer happens on a rising edge where valid & ready are both 1.
    // An operand is taken only while the result slot is empty or being drained
    // this cycle; the requester holds data/mode stable until it sees ready.
    logic        can_accept;
    logic        grant;
    logic        accept;
    logic        last_grant;
    logic [31:0] sel_d;
    logic [1:0]  sel_mode;
    logic [23:0] range_max;
    logic [23:0] sat_q;
    logic        sat_clamped;

    assign can_accept = !reset && (!res_valid || res_ready);

    // Alternate on contention; otherwise whichever side is asking wins.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    assign req0_ready = can_accept && req0_valid && !grant;
    assign req1_ready = can_accept && req1_valid && grant;
    assign accept     = req0_ready || req1_ready;

    assign sel_d    = grant ? req1_d : req0_d;
    assign sel_mode = grant ? req1_mode : req0_mode;

    // The twentyfour bit overrides sixteen.
    always_comb begin
        range_max = 24'h0000FF;
        if (sel_mode[1]) begin
            range_max = 24'hFFFFFF;
        end else if (sel_mode[0]) begin
            range_max = 24'h00FFFF;
        end
    end

    always_comb begin
        sat_q       = sel_d[23:0];
        sat_clamped = 1'b0;
        if (sel_d[31]) begin
            sat_q       = 24'h000000;
            sat_clamped = 1'b1;
        end else if (sel_d[30:0] > {7'b0, range_max}) begin
            sat_q       = range_max;
            sat_clamped = 1'b1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            res_valid   <= 1'b0;
            res_q       <= 24'h000000;
            res_id      <= 1'b0;
            res_clamped <= 1'b0;
            last_grant  <= 1'b1;
        end else if (accept) begin
            res_valid   <= 1'b1;
            res_q       <= sat_q;
            res_id      <= grant;
            res_clamped <= sat_clamped;
            last_grant  <= grant;
        end else if (res_ready) begin
            res_valid   <= 1'b0;
        end
    end

    // Clear beats a same-cycle clamp; the count sticks at all-ones.
    always_ff @(posedge sys_clk) begin
        if (reset || cnt_clr) begin
            sat_cnt <= '0;
        end else if (accept && sat_clamped && (sat_cnt != {CNT_W{1'b1}})) begin
            sat_cnt <= sat_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_sat_arb.sv
// Directed bench for sat_arb: a table of single operations with hand-computed
// results, then hand-written sequences for contention, stalls and reset.
module tb_sat_arb;

    logic        sys_clk;
    logic        reset;
    logic        req0_valid;
    logic        req0_ready;
    logic [31:0] req0_d;
    logic [1:0]  req0_mode;
    logic        req1_valid;
    logic        req1_ready;
    logic [31:0] req1_d;
    logic [1:0]  req1_mode;
    logic        res_valid;
    logic        res_ready;
    logic [23:0] res_q;
    logic        res_id;
    logic        res_clamped;
    logic [1:0]  sat_cnt;
    logic        cnt_clr;

    int checks = 0;
    int errors = 0;
    logic [24:0] exp_q[$];

    sat_arb #(.CNT_W(2)) dut (
        .sys_clk     (sys_clk),
        .reset       (reset),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_d      (req0_d),
        .req0_mode   (req0_mode),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_d      (req1_d),
        .req1_mode   (req1_mode),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_q       (res_q),
        .res_id      (res_id),
        .res_clamped (res_clamped),
        .sat_cnt     (sat_cnt),
        .cnt_clr     (cnt_clr)
    );

    // clock / reset
    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic        id;
        logic [31:0] d;
        logic [1:0]  mode;
        logic [23:0] q;
        logic        clamped;
        logic [1:0]  cnt;
    } vec_t;

    vec_t vecs[12];

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic drive_req(input logic id, input logic [31:0] d, input logic [1:0] mode);
        if (id) begin
            req1_valid = 1'b1;
            req1_d     = d;
            req1_mode  = mode;
        end else begin
            req0_valid = 1'b1;
            req0_d     = d;
            req0_mode  = mode;
        end
    endtask

    task automatic idle_reqs();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    initial begin
        logic [24:0] e;

        vecs[0]  = '{1'b0, 32'h00012345, 2'b01, 24'h00FFFF, 1'b1, 2'd1};
        vecs[1]  = '{1'b1, 32'hFFFFFF80, 2'b10, 24'h000000, 1'b1, 2'd2};
        vecs[2]  = '{1'b1, 32'h00ABCDEF, 2'b11, 24'hABCDEF, 1'b0, 2'd2};
        vecs[3]  = '{1'b0, 32'h000000FF, 2'b00, 24'h0000FF, 1'b0, 2'd2};
        vecs[4]  = '{1'b0, 32'h00000100, 2'b00, 24'h0000FF, 1'b1, 2'd3};
        vecs[5]  = '{1'b1, 32'h0000FFFF, 2'b01, 24'h00FFFF, 1'b0, 2'd3};
        vecs[6]  = '{1'b0, 32'h00FFFFFF, 2'b10, 24'hFFFFFF, 1'b0, 2'd3};
        vecs[7]  = '{1'b1, 32'h01000000, 2'b11, 24'hFFFFFF, 1'b1, 2'd3};
        vecs[8]  = '{1'b0, 32'h80000000, 2'b00, 24'h000000, 1'b1, 2'd3};
        vecs[9]  = '{1'b0, 32'h7FFFFFFF, 2'b01, 24'h00FFFF, 1'b1, 2'd3};
        vecs[10] = '{1'b1, 32'h00000000, 2'b00, 24'h000000, 1'b0, 2'd3};
        vecs[11] = '{1'b0, 32'h00012345, 2'b00, 24'h0000FF, 1'b1, 2'd3};

        reset      = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_d     = '0;
        req1_d     = '0;
        req0_mode  = '0;
        req1_mode  = '0;
        res_ready  = 1'b0;
        cnt_clr    = 1'b0;

        // reset state, with a request pending that must not be taken
        tick();
        drive_req(1'b0, 32'h00000100, 2'b00);
        settle();
        check("rst_ready0", req0_ready, 0);
        tick();
        check("rst_valid", res_valid, 0);
        check("rst_q", res_q, 0);
        check("rst_id", res_id, 0);
        check("rst_clamped", res_clamped, 0);
        check("rst_cnt", sat_cnt, 0);
        idle_reqs();
        reset = 1'b0;

        // table: one operation at a time, drained immediately
        res_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            drive_req(vecs[i].id, vecs[i].d, vecs[i].mode);
            settle();
            check($sformatf("v%0d_ready", i), vecs[i].id ? req1_ready : req0_ready, 1);
            check($sformatf("v%0d_other", i), vecs[i].id ? req0_ready : req1_ready, 0);
            exp_q.push_back({vecs[i].clamped, vecs[i].q});
            tick();
            idle_reqs();
            e = exp_q.pop_front();
            check($sformatf("v%0d_valid", i), res_valid, 1);
            check($sformatf("v%0d_q", i), res_q, e[23:0]);
            check($sformatf("v%0d_clamped", i), res_clamped, e[24]);
            check($sformatf("v%0d_id", i), res_id, vecs[i].id);
            check($sformatf("v%0d_cnt", i), sat_cnt, vecs[i].cnt);
            tick();
            check($sformatf("v%0d_drain", i), res_valid, 0);
        end

        // clear wins over a same-cycle clamp
        drive_req(1'b0, 32'h00020000, 2'b01);
        cnt_clr = 1'b1;
        tick();
        idle_reqs();
        cnt_clr = 1'b0;
        check("clr_cnt", sat_cnt, 0);
        check("clr_clamped", res_clamped, 1);
        check("clr_q", res_q, 24'h00FFFF);
        tick();

        // reset while a result is held
        res_ready = 1'b0;
        drive_req(1'b0, 32'h00000100, 2'b00);
        tick();
        check("hold_pre_valid", res_valid, 1);
        check("hold_pre_cnt", sat_cnt, 1);
        reset = 1'b1;
        drive_req(1'b1, 32'h00000005, 2'b00);
        settle();
        check("rst2_ready0", req0_ready, 0);
        check("rst2_ready1", req1_ready, 0);
        tick();
        check("rst2_valid", res_valid, 0);
        check("rst2_cnt", sat_cnt, 0);
        check("rst2_q", res_q, 0);
        reset = 1'b0;

        // continuous contention: grants alternate starting with requester 0
        res_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            settle();
            check($sformatf("rr%0d_ready0", k), req0_ready, (k % 2) == 0);
            check($sformatf("rr%0d_ready1", k), req1_ready, (k % 2) == 1);
            if (k > 0) begin
                check($sformatf("rr%0d_valid", k), res_valid, 1);
                check($sformatf("rr%0d_id", k), res_id, (k - 1) % 2);
            end
            tick();
        end
        check("rr4_valid", res_valid, 1);
        check("rr4_id", res_id, 1);

        // stall three cycles: result holds, nobody is accepted
        res_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            settle();
            check($sformatf("st%0d_ready0", k), req0_ready, 0);
            check($sformatf("st%0d_ready1", k), req1_ready, 0);
            tick();
            check($sformatf("st%0d_valid", k), res_valid, 1);
            check($sformatf("st%0d_q", k), res_q, 24'h000005);
            check($sformatf("st%0d_id", k), res_id, 1);
            check($sformatf("st%0d_clamped", k), res_clamped, 0);
        end

        // release: drain and accept in the same cycle, priority did not rotate
        res_ready = 1'b1;
        settle();
        check("rel_ready0", req0_ready, 1);
        check("rel_ready1", req1_ready, 0);
        tick();
        idle_reqs();
        check("rel_valid", res_valid, 1);
        check("rel_id", res_id, 0);
        check("rel_q", res_q, 24'h0000FF);
        check("rel_clamped", res_clamped, 1);
        tick();
        check("end_drain", res_valid, 0);
        tick();
        check("end_idle", res_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sat_arb.md
SAT_ARB -- requirements
Module: sat_arb

Interface
REQ-001 Parameter CNT_W, default 16, SHALL set the width of the saturation-event counter.
REQ-002 sys_clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 reset  input  1  SHALL be a synchronous, active-high reset sampled on sys_clk.
REQ-004 req0_valid / req1_valid  input  1 each  SHALL flag a pending saturate request from requester 0 (GPU) / 1 (DSP).
REQ-005 req0_ready / req1_ready  output  1 each  SHALL flag acceptance of that requester's operand this cycle.
REQ-006 req0_d / req1_d  input  32 each  SHALL carry the signed two's-complement operand.
REQ-007 req0_mode / req1_mode  input  2 each  SHALL select the clamp: bit1 = twentyfour, bit0 = sixteen.
REQ-008 res_valid  output  1  SHALL flag a valid result in the output register.
REQ-009 res_ready  input  1  SHALL flag that the consumer takes the result this cycle.
REQ-010 res_q  output  24  SHALL carry the saturated result, zero-extended to 24 bits.
REQ-011 res_id  output  1  SHALL identify the requester (0/1) that owns res_q.
REQ-012 res_clamped  output  1  SHALL flag that res_q differs from the operand's low bits because of clamping.
REQ-013 sat_cnt  output  CNT_W  SHALL count accepted operations that clamped.
REQ-014 cnt_clr  input  1  SHALL clear sat_cnt synchronously.

Function
REQ-015 Clamp range SHALL be 0..0xFF for mode 00, 0..0xFFFF for mode 01, and 0..0xFFFFFF for mode 10 or 11 (twentyfour overrides sixteen).
REQ-016 Negative operand (d[31]=1) SHALL yield res_q=0 with res_clamped=1.
REQ-017 Operand above the range maximum SHALL yield res_q=maximum with res_clamped=1; an operand in range SHALL pass through unchanged with res_clamped=0.
REQ-018 The block SHALL accept at most one operand per cycle, and only when res_valid=0 or (res_valid & res_ready)=1 in that cycle.
REQ-019 reqN_ready SHALL be combinational: 1 only for the granted requester while the acceptance condition of REQ-018 holds; the ungranted requester SHALL see 0.
REQ-020 Arbitration SHALL be round-robin: with both requesters valid, grant the one not granted at the last acceptance; with one requester valid, grant it.
REQ-021 last_grant SHALL update only on an acceptance, so a stalled output does not rotate priority.
REQ-022 Latency SHALL be one cycle: an operand accepted in cycle N SHALL appear on res_q/res_id/res_clamped with res_valid=1 in cycle N+1.
REQ-023 While res_valid=1 and res_ready=0, res_q, res_id and res_clamped SHALL hold stable.
REQ-024 When res_ready=1 with no new acceptance, res_valid SHALL drop to 0 in the next cycle; drain plus acceptance in one cycle SHALL give back-to-back results, one per cycle.
REQ-025 res_ready while res_valid=0 SHALL have no effect.
REQ-026 sat_cnt SHALL increment by 1 per accepted clamping operation and SHALL stick at all-ones (no wrap).
REQ-027 cnt_clr and a clamping acceptance in the same cycle SHALL leave sat_cnt=0 (clear wins).
REQ-028 A requester SHALL hold reqN_d/reqN_mode stable while reqN_valid=1 and reqN_ready=0; the block latches them only on acceptance.

Reset
REQ-029 reset=1 SHALL set res_valid=0, res_q=0, res_id=0, res_clamped=0, sat_cnt=0, and last_grant=1 (requester 0 wins the first contention).
REQ-030 During reset, req0_ready and req1_ready SHALL be 0, and no operand SHALL be accepted.
REQ-031 reset asserted mid-operation SHALL discard any held result without further handshake, and operation SHALL resume in the first cycle after release.

Verification
REQ-032 req0 d=0x00012345 mode=01, res_ready=1 -> next cycle res_valid=1, res_q=0x00FFFF, res_id=0, res_clamped=1, sat_cnt=1.
REQ-033 req1 d=0xFFFFFF80 mode=10 -> res_q=0x000000, res_clamped=1; then d=0x00ABCDEF mode=11 -> res_q=0xABCDEF, res_clamped=0.
REQ-034 Both requesters valid continuously, res_ready=1 -> res_id sequence 0,1,0,1, one result per cycle after first.
REQ-035 res_ready=0 for 3 cycles with result held -> res_q stable, reqN_ready=0 throughout; res_ready=1 -> drain and new acceptance in same cycle.
REQ-036 CNT_W=2, four clamping operations -> sat_cnt 1,2,3,3; cnt_clr concurrent with a fifth clamp -> sat_cnt=0.
REQ-037 reset pulsed while res_valid=1 -> next cycle res_valid=0, sat_cnt=0; first contention after release is granted to requester 0.
